// File: rtl/wshb_arb_pkg.sv
// wshb_arb_pkg: state, owner and Wishbone constants shared by the arbiter and its mux
package wshb_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10} arb_state_t;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_M0 = 2'b01;
  localparam logic [1:0] OWNER_M1 = 2'b10;
endpackage

// File: rtl/wshb_arb_mux.sv
// wshb_arb_mux: combinational slave/master signal steering from the arbiter state.
//   state       current grant (IDLE/GNT0/GNT1)
//   stall       owner held off the bus (s_cyc, s_stb and acks forced low)
//   m0_*/m1_*   master-side Wishbone signals, s_* slave-side signals
module wshb_arb_mux
  import wshb_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  arb_state_t              state,
  input  logic                    stall,
  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [ADDR_W-1:0]       m0_adr,
  input  logic [DATA_W-1:0]       m0_dat_ms,
  input  logic [DATA_W/8-1:0]     m0_sel,
  input  logic [2:0]              m0_cti,
  input  logic [1:0]              m0_bte,
  output logic                    m0_ack,
  output logic [DATA_W-1:0]       m0_dat_sm,
  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [ADDR_W-1:0]       m1_adr,
  input  logic [DATA_W-1:0]       m1_dat_ms,
  input  logic [DATA_W/8-1:0]     m1_sel,
  input  logic [2:0]              m1_cti,
  input  logic [1:0]              m1_bte,
  output logic                    m1_ack,
  output logic [DATA_W-1:0]       m1_dat_sm,
  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [ADDR_W-1:0]       s_adr,
  output logic [DATA_W-1:0]       s_dat_ms,
  output logic [DATA_W/8-1:0]     s_sel,
  output logic [2:0]              s_cti,
  output logic [1:0]              s_bte,
  input  logic                    s_ack,
  input  logic [DATA_W-1:0]       s_dat_sm
);
  logic g0, g1;
  assign g0 = state == GNT0;
  assign g1 = state == GNT1;
  assign s_cyc = !stall && (g0 ? m0_cyc : g1 && m1_cyc);
  assign s_stb = !stall && (g0 ? m0_stb : g1 && m1_stb);
  assign s_we = g0 ? m0_we : g1 && m1_we;
  assign s_adr = g0 ? m0_adr : g1 ? m1_adr : '0;
  assign s_dat_ms = g0 ? m0_dat_ms : g1 ? m1_dat_ms : '0;
  assign s_sel = g0 ? m0_sel : g1 ? m1_sel : '0;
  assign s_cti = g0 ? m0_cti : g1 ? m1_cti : CTI_CLASSIC;
  assign s_bte = g0 ? m0_bte : g1 ? m1_bte : BTE_LINEAR;
  // gating with the owner's cyc drops a late ack that lands as the owner releases
  assign m0_ack = g0 && !stall && m0_cyc && s_ack;
  assign m1_ack = g1 && !stall && m1_cyc && s_ack;
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;
endmodule

// File: rtl/wshb_arbiter.sv
// wshb_arbiter: round-robin two-master / one-slave Wishbone arbiter in front of the SDRAM port.
//   clk, rst_n            clock and synchronous active-low reset
//   m0_*                  video/test-pattern writer master
//   m1_*                  display frame reader master
//   s_*                   shared slave port
//   owner                 debug: 00 none, 01 m0, 10 m1
// Build option WSHB_ARB_QUOTA_EN: cap the owner at QUOTA acks while the other master waits.
module wshb_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int QUOTA = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [ADDR_W-1:0]       m0_adr,
  input  logic [DATA_W-1:0]       m0_dat_ms,
  input  logic [DATA_W/8-1:0]     m0_sel,
  input  logic [2:0]              m0_cti,
  input  logic [1:0]              m0_bte,
  output logic                    m0_ack,
  output logic [DATA_W-1:0]       m0_dat_sm,
  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [ADDR_W-1:0]       m1_adr,
  input  logic [DATA_W-1:0]       m1_dat_ms,
  input  logic [DATA_W/8-1:0]     m1_sel,
  input  logic [2:0]              m1_cti,
  input  logic [1:0]              m1_bte,
  output logic                    m1_ack,
  output logic [DATA_W-1:0]       m1_dat_sm,
  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [ADDR_W-1:0]       s_adr,
  output logic [DATA_W-1:0]       s_dat_ms,
  output logic [DATA_W/8-1:0]     s_sel,
  output logic [2:0]              s_cti,
  output logic [1:0]              s_bte,
  input  logic                    s_ack,
  input  logic [DATA_W-1:0]       s_dat_sm,
  output logic [1:0]              owner
);
  arb_state_t state, state_nx;
  logic last_gnt, rel, stall;
  if (QUOTA < 1) begin : g_quota_chk
    $error("wshb_arbiter: QUOTA must be at least 1");
  end
  // rel: the owner gives up the bus at this edge (cyc dropped or quota yield)
  assign rel = state == GNT0 ? !m0_cyc || stall : state == GNT1 && (!m1_cyc || stall);
  always_comb
    state_nx = state == GNT0 ? (!rel ? GNT0 : m1_cyc ? GNT1 : IDLE) :
               state == GNT1 ? (!rel ? GNT1 : m0_cyc ? GNT0 : IDLE) :
               m0_cyc && (!m1_cyc || last_gnt) ? GNT0 : m1_cyc ? GNT1 : IDLE;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state <= state_nx;
      if (rel) last_gnt <= state == GNT1;
    end
`ifdef WSHB_ARB_QUOTA_EN
  localparam int CW = $clog2(QUOTA + 1);
  logic [CW-1:0] cnt;
  logic other_cyc;
  assign other_cyc = state == GNT0 ? m1_cyc : state == GNT1 && m0_cyc;
  // the stall cycle keeps cyc/stb low for one cycle so any in-flight ack settles before handover
  assign stall = state != IDLE && cnt == CW'(QUOTA) && other_cyc;
  always_ff @(posedge clk)
    if (!rst_n || state_nx != state) cnt <= '0;
    else if ((m0_ack || m1_ack) && cnt != CW'(QUOTA)) cnt <= cnt + CW'(1);
`else
  assign stall = 1'b0;
`endif
  assign owner = state == GNT0 ? OWNER_M0 : state == GNT1 ? OWNER_M1 : OWNER_NONE;
  wshb_arb_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .state(state), .stall(stall),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_dat_ms(m0_dat_ms),
    .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte), .m0_ack(m0_ack), .m0_dat_sm(m0_dat_sm),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_dat_ms(m1_dat_ms),
    .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte), .m1_ack(m1_ack), .m1_dat_sm(m1_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_ms(s_dat_ms),
    .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte), .s_ack(s_ack), .s_dat_sm(s_dat_sm)
  );
endmodule
